// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM state encoding for the sequential divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration, purely combinational (zero latency, no flow control).
// Trial subtract is P + ~D + 1; carry out clear means borrow, so P is restored.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p_shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit,
  output logic             borrow
);

  logic [WIDTH+1:0] sum;

  assign sum    = {1'b0, p_shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign borrow = ~sum[WIDTH+1];
  assign q_bit  = sum[WIDTH+1];
  assign p_next = borrow ? p_shifted : sum[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock; done WIDTH+1 cycles after accept (1 for divide-by-zero).
// start is only taken in IDLE/DONE; while busy it is ignored, nothing is queued.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_shifted;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;
  logic             borrow;
  logic             last_iter;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign p_shifted = {p[WIDTH-1:0], q[WIDTH-1]};
  assign q_next    = {q[WIDTH-2:0], q_bit};
  assign last_iter = (cnt == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_shifted (p_shifted),
    .divisor   (dsr),
    .p_next    (p_next),
    .q_bit     (q_bit),
    .borrow    (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      q         <= '0;
      dsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dsr <= divisor;
            p   <= '0;
            q   <= dividend;
            cnt <= '0;
            // Divide-by-zero skips the iterations and completes immediately.
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div0      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p   <= p_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            quotient  <= q_next;
            remainder <= p_next[WIDTH-1:0];
            div0      <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Partial remainder stays below the divisor, so its top bit is clear between iterations.
  a_p_msb_clear: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> (!p[WIDTH] && (q_bit == !borrow)));

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded bench for seq_divider: directed vectors plus a short random batch.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one start pulse from a negedge; returns on the following negedge.
  task automatic issue(input int dd, input int dv, input bit push,
                       input int eq, input int er, input bit ed);
    exp_t e;
    dividend = 8'(dd);
    divisor  = 8'(dv);
    start    = 1'b1;
    if (push) begin
      e.q  = 8'(eq);
      e.r  = 8'(er);
      e.d0 = ed;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = negedges already elapsed since the accept edge.
  task automatic wait_done(input string name, input int n0, input int exp_lat, input int exp_busy);
    int n = n0;
    int b = 0;
    while (!done && n < 40) begin
      if (busy) b++;
      @(negedge clk);
      n++;
    end
    chk({name, " done latency"}, n, exp_lat);
    chk({name, " busy cycles"}, b, exp_busy);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", int'(quotient), int'(mon_e.q));
        chk("remainder", int'(remainder), int'(mon_e.r));
        chk("div0", int'(div0), int'(mon_e.d0));
      end
    end
  end

  initial begin
    #3;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset div0", int'(div0), 0);
    #4 rst_n = 1'b1;
    @(negedge clk);

    issue(200, 7, 1'b1, 28, 4, 1'b0);
    wait_done("200/7", 1, 9, 8);
    @(negedge clk);
    chk("200/7 done single pulse", int'(done), 0);

    issue(255, 1, 1'b1, 255, 0, 1'b0);
    wait_done("255/1", 1, 9, 8);
    repeat (3) @(negedge clk);
    chk("hold quotient", int'(quotient), 255);
    chk("hold remainder", int'(remainder), 0);
    chk("idle busy", int'(busy), 0);
    chk("idle done", int'(done), 0);
    issue(5, 9, 1'b1, 0, 5, 1'b0);
    wait_done("5/9", 1, 9, 8);
    @(negedge clk);

    issue(100, 0, 1'b1, 255, 100, 1'b1);
    wait_done("100/0", 1, 1, 0);
    @(negedge clk);
    chk("div0 hold", int'(div0), 1);
    chk("div0 idle busy", int'(busy), 0);

    issue(17, 17, 1'b1, 1, 0, 1'b0);
    @(negedge clk);
    dividend = 8'd1;
    divisor  = 8'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    wait_done("17/17", 3, 9, 6);
    issue(255, 16, 1'b1, 15, 15, 1'b0);
    wait_done("255/16 back-to-back", 1, 9, 8);
    @(negedge clk);

    issue(144, 12, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(done), 0);
    chk("async reset quotient", int'(quotient), 0);
    chk("async reset remainder", int'(remainder), 0);
    chk("async reset div0", int'(div0), 0);
    repeat (12) @(negedge clk);
    chk("no done after abort", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(144, 12, 1'b1, 12, 0, 1'b0);
    wait_done("144/12", 1, 9, 8);

    for (int i = 0; i < 150; i++) begin
      int dd;
      int dv;
      dd = int'($urandom_range(0, 255));
      dv = int'($urandom_range(1, 255));
      issue(dd, dv, 1'b1, dd / dv, dd % dv, 1'b0);
      wait_done("random", 1, 9, 8);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
